// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the requester handshake signals and the data-memory
//               bus shared by dmem_arbiter. The arbiter connects through the
//               slave modport. The master modport is the environment side,
//               meaning the requesters plus the memory.
//   req0_* / req1_*   : request valid, write flag, address, write data
//   req0/1_ready      : request accepted this cycle
//   resp0/1_valid     : one-cycle completion pulse
//   resp_rdata        : shared read data, valid with either resp pulse
//   mem_*             : memory address/write data/write enable/read enable,
//                       plus the combinational read data returned by memory
//   busy              : arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              resp0_valid;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              resp1_valid;

  logic [DATA_W-1:0] resp_rdata;

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_read_data,
    output req0_ready, resp0_valid, req1_ready, resp1_valid, resp_rdata,
    output mem_access_addr, mem_write_data, mem_write_en, mem_read,
    output busy
  );

  // Requesters and memory side
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_read_data,
    input  req0_ready, resp0_valid, req1_ready, resp1_valid, resp_rdata,
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter that shares a single-ported data memory
//               between requester 0 (CPU load/store) and requester 1
//               (debug/DMA). It runs one access at a time through the states
//               IDLE -> ACCESS -> RESP, so a new access can start at most
//               once every three cycles.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester handshakes and memory bus (dmem_arbiter_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dmem_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              last_grant_q;
  logic              grant_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_valid;
  logic              winner;
  logic              accept;

  // Arbitration: a lone requester wins. On a tie, the port that was not
  // granted last time wins, so continuous contention alternates the grants.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = bus.req1_valid;
    end
    accept = (state_q == IDLE) && any_valid;
  end

  // State register and request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // port 0 takes the first tie after reset
      grant_q      <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q      <= winner;
        last_grant_q <= winner;
        lat_we_q     <= winner ? bus.req1_we    : bus.req0_we;
        lat_addr_q   <= winner ? bus.req1_addr  : bus.req0_addr;
        lat_wdata_q  <= winner ? bus.req1_wdata : bus.req0_wdata;
      end
      // Read data is captured on the edge that closes ACCESS. Writes leave
      // the previous read value in place.
      if ((state_q == ACCESS) && !lat_we_q) begin
        rdata_q <= bus.mem_read_data;
      end
    end
  end

  // Next state and outputs. The memory enables decode from state_q alone,
  // so an asynchronous reset during ACCESS drops them at once and the write
  // never reaches its commit edge.
  always_comb begin
    state_d             = state_q;
    bus.req0_ready      = 1'b0;
    bus.req1_ready      = 1'b0;
    bus.resp0_valid     = 1'b0;
    bus.resp1_valid     = 1'b0;
    bus.mem_access_addr = '0;
    bus.mem_write_data  = '0;
    bus.mem_write_en    = 1'b0;
    bus.mem_read        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = ACCESS;
        end
        bus.req0_ready = any_valid & ~winner;
        bus.req1_ready = any_valid &  winner;
      end
      ACCESS: begin
        state_d             = RESP;
        bus.mem_access_addr = lat_addr_q;
        bus.mem_write_data  = lat_wdata_q;
        bus.mem_write_en    = lat_we_q;
        bus.mem_read        = ~lat_we_q;
      end
      RESP: begin
        state_d         = IDLE;
        bus.resp0_valid = ~grant_q;
        bus.resp1_valid =  grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed bench for dmem_arbiter. It applies a table of
//               per-cycle request vectors with hand-computed outputs, then
//               runs hand-written sequences for reset during a write and for
//               tie-break after reset. A 256-word memory model sits on the
//               memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: write commits on posedge, read is combinational and gated.
  logic [15:0] mem [0:255];
  always @(posedge clk or posedge mem_init) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[5] <= 16'hBEEF;
    end else if (bus.mem_write_en) begin
      mem[bus.mem_access_addr[7:0]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_access_addr[7:0]] : 16'h0000;

  typedef struct {
    logic        v0, we0;
    logic [15:0] a0, d0;
    logic        v1, we1;
    logic [15:0] a1, d1;
    // expected {rdy0, rdy1, rsp0, rsp1, mem_we, mem_rd, addr, wdata, rdata, busy}
    logic [54:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic v0, input logic we0, input logic [15:0] a0, input logic [15:0] d0,
    input logic v1, input logic we1, input logic [15:0] a1, input logic [15:0] d1,
    input logic r0, input logic r1, input logic s0, input logic s1,
    input logic mwe, input logic mrd, input logic [15:0] maddr, input logic [15:0] mwd,
    input logic [15:0] rd, input logic bsy);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.exp = {r0, r1, s0, s1, mwe, mrd, maddr, mwd, rd, bsy};
    return v;
  endfunction

  function automatic logic [54:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid,
            bus.mem_write_en, bus.mem_read, bus.mem_access_addr,
            bus.mem_write_data, bus.resp_rdata, bus.busy};
  endfunction

  task automatic check(input string name, input logic [54:0] got, input logic [54:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b%b rsp=%b%b we=%b rd=%b addr=%h wd=%h rdata=%h busy=%b, want rdy=%b%b rsp=%b%b we=%b rd=%b addr=%h wd=%h rdata=%h busy=%b",
               name, got[54], got[53], got[52], got[51], got[50], got[49], got[48:33], got[32:17], got[16:1], got[0],
               exp[54], exp[53], exp[52], exp[51], exp[50], exp[49], exp[48:33], exp[32:17], exp[16:1], exp[0]);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0_valid = v.v0; bus.req0_we = v.we0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
    bus.req1_valid = v.v1; bus.req1_we = v.we1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
  endtask

  // Called at a negedge: drive, settle, compare, advance to the next negedge.
  task automatic step(input string name, input vec_t v);
    drive(v);
    #1;
    check(name, outs(), v.exp);
    @(negedge clk);
  endtask

  vec_t nv;
  logic [15:0] word5;

  initial begin
    nv = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 16'h0,0);
    drive(nv);
    #1 mem_init = 1'b1;
    #1 mem_init = 1'b0;
    #1;
    check("reset_outputs", outs(), 55'd0);

    // single write, read-back, idle bus, then contention with an address
    // change after acceptance
    vecs.push_back(mk(1,1,16'd3,16'hA5A5, 0,0,0,0,        1,0,0,0, 0,0,16'd0,16'h0,    16'h0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,0,0, 1,0,16'd3,16'hA5A5, 16'h0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,1,0, 0,0,16'd0,16'h0,    16'h0,1));
    vecs.push_back(mk(0,0,0,0, 1,0,16'd3,16'h5555,        0,1,0,0, 0,0,16'd0,16'h0,    16'h0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,1,16'd3,16'h5555, 16'h0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,0,1, 0,0,16'd0,16'h0,    16'hA5A5,1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,                 0,0,0,0, 0,0,16'd0,16'h0,    16'hA5A5,0));
    vecs.push_back(mk(1,0,16'd2,0, 1,0,16'd3,0,           1,0,0,0, 0,0,16'd0,16'h0,    16'hA5A5,0));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,0,0,0, 0,1,16'd2,16'h0,    16'hA5A5,1));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,0,1,0, 0,0,16'd0,16'h0,    16'h0,1));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,1,0,0, 0,0,16'd0,16'h0,    16'h0,0));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,0,0,0, 0,1,16'd3,16'h0,    16'h0,1));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,0,0,1, 0,0,16'd0,16'h0,    16'hA5A5,1));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           1,0,0,0, 0,0,16'd0,16'h0,    16'hA5A5,0));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,0,0,0, 0,1,16'd7,16'h0,    16'hA5A5,1));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,0,1,0, 0,0,16'd0,16'h0,    16'h0,1));
    vecs.push_back(mk(1,0,16'd7,0, 1,0,16'd3,0,           0,1,0,0, 0,0,16'd0,16'h0,    16'h0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,1,16'd3,16'h0,    16'h0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,0,1, 0,0,16'd0,16'h0,    16'hA5A5,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,                   0,0,0,0, 0,0,16'd0,16'h0,    16'hA5A5,0));

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted in the middle of an ACCESS write
    step("midwr_accept", mk(1,1,16'd5,16'h1234, 0,0,0,0,  1,0,0,0, 0,0,16'd0,16'h0, 16'hA5A5,0));
    drive(nv);
    #1;
    check("midwr_access", outs(), {6'b000010, 16'd5, 16'h1234, 16'hA5A5, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("midwr_reset_async", outs(), 55'd0);
    @(negedge clk);
    word5 = mem[5];
    check("midwr_word5_kept", {39'd0, word5}, {39'd0, 16'hBEEF});
    check("midwr_no_resp", outs(), 55'd0);
    rst_n = 1'b1;

    // Tie on the first IDLE after reset: port 0 first, then port 1
    step("tie_rdy0",   mk(1,0,16'd5,0, 1,0,16'd3,0,  1,0,0,0, 0,0,16'd0,16'h0, 16'h0,0));
    step("tie_acc0",   mk(1,0,16'd5,0, 1,0,16'd3,0,  0,0,0,0, 0,1,16'd5,16'h0, 16'h0,1));
    step("tie_rsp0",   mk(1,0,16'd5,0, 1,0,16'd3,0,  0,0,1,0, 0,0,16'd0,16'h0, 16'hBEEF,1));
    step("tie_rdy1",   mk(0,0,0,0,     1,0,16'd3,0,  0,1,0,0, 0,0,16'd0,16'h0, 16'hBEEF,0));
    step("tie_acc1",   mk(0,0,0,0,     0,0,0,0,      0,0,0,0, 0,1,16'd3,16'h0, 16'hBEEF,1));
    step("tie_rsp1",   mk(0,0,0,0,     0,0,0,0,      0,0,0,1, 0,0,16'd0,16'h0, 16'hA5A5,1));
    step("final_idle", mk(0,0,0,0,     0,0,0,0,      0,0,0,0, 0,0,16'd0,16'h0, 16'hA5A5,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
